// File: rtl/pulse_pattern_scheduler.sv
// rtl/pulse_pattern_scheduler.sv - two-requester round-robin pulse pattern dwell scheduler
module pulse_pattern_scheduler #(
    parameter int DUR_W = 8
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             req0,
    input  logic [15:0]      pat0,
    input  logic [DUR_W-1:0] dur0,
    input  logic             req1,
    input  logic [15:0]      pat1,
    input  logic [DUR_W-1:0] dur1,
    input  logic             stop,
    output logic             gnt0,
    output logic             gnt1,
    output logic [15:0]      Q_in,
    output logic             load,
    output logic             busy,
    output logic             active_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state;
    logic [DUR_W-1:0] cnt;
    logic             rr_ptr;
    logic             any_req;
    logic             winner;

    // A lone request always wins; on a tie the round-robin pointer decides.
    assign any_req = req0 | req1;
    assign winner  = (req0 & req1) ? rr_ptr : req1;

    // Scheduler FSM: every output is a register updated alongside the state.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= 1'b0;
            Q_in      <= 16'h0000;
            load      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
            active_id <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= LOAD;
                        Q_in      <= winner ? pat1 : pat0;
                        cnt       <= winner ? dur1 : dur0;
                        gnt0      <= ~winner;
                        gnt1      <= winner;
                        load      <= 1'b1;
                        busy      <= 1'b1;
                        active_id <= winner;
                        rr_ptr    <= ~winner;
                    end
                end
                LOAD: begin
                    // Single-cycle strobe; a zero dwell returns straight to IDLE.
                    load <= 1'b0;
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Leaving on cnt==1 gives exactly dur RUN cycles and no wrap.
                    if (stop || (cnt == DUR_W'(1))) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - DUR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    load  <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pulse_pattern_scheduler.md
PULSE_PATTERN_SCHEDULER -- requirements
Module: pulse_pattern_scheduler

Interface
REQ-001 The block SHALL have parameter DUR_W, default 8, giving the width of the dwell-duration fields.
REQ-002 The block SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port req0  input  1  requester 0 level request; held high until gnt0 is seen.
REQ-005 The block SHALL have port pat0  input  16  requester 0 pulse pattern, sampled at grant.
REQ-006 The block SHALL have port dur0  input  DUR_W  requester 0 dwell length in CLK cycles, sampled at grant.
REQ-007 The block SHALL have ports req1 (input, 1), pat1 (input, 16) and dur1 (input, DUR_W), with the same meanings for requester 1.
REQ-008 The block SHALL have port stop  input  1  abort of the current dwell.
REQ-009 The block SHALL have ports gnt0 and gnt1  output  1  one-cycle grant acknowledge to each requester.
REQ-010 The block SHALL have port Q_in  output  16  pattern bus to the pulse generator.
REQ-011 The block SHALL have port load  output  1  load strobe to the pulse generator.
REQ-012 The block SHALL have port busy  output  1  high in LOAD and RUN.
REQ-013 The block SHALL have port active_id  output  1  index of the requester most recently granted.

Function
REQ-014 FSM states SHALL be IDLE, LOAD and RUN, and all outputs SHALL be registered.
REQ-015 IDLE with (req0|req1) at a rising edge: the FSM SHALL go to LOAD, latch the selected pat into Q_in and the selected dur into the counter, set gnt of the winner, set active_id to the winner, and toggle the round-robin pointer to the loser.
REQ-016 Arbitration: a single request SHALL win; on simultaneous requests, the requester indicated by the round-robin pointer SHALL win.
REQ-017 LOAD SHALL last exactly 1 cycle, with load=1 and the winner's gnt=1; load and gnt SHALL be 0 in every other state.
REQ-018 LOAD exit: counter==0 SHALL go to IDLE; otherwise the FSM SHALL go to RUN.
REQ-019 RUN: the counter SHALL decrement each edge, and the FSM SHALL go to IDLE on the edge where the counter equals 1, so RUN lasts exactly dur cycles.
REQ-020 stop=1 sampled in RUN SHALL force IDLE at that edge and clear the counter; stop SHALL be ignored in IDLE and LOAD.
REQ-021 Q_in SHALL hold the last latched pattern through RUN and IDLE, changing only on entry to LOAD, so the generator keeps running after the dwell ends.
REQ-022 Requests arriving in LOAD or RUN SHALL be ignored until IDLE, and a pending request SHALL be granted on the first IDLE edge (IDLE lasts 1 cycle when a request is waiting).
REQ-023 A requester SHALL drop req at the edge where it samples gnt=1; a req still high in IDLE SHALL be treated as a new request.
REQ-024 The counter SHALL be DUR_W bits wide and SHALL never underflow or wrap; a dur of all-ones SHALL give 2^DUR_W-1 RUN cycles.
REQ-025 Back-to-back grants SHALL alternate between requesters while both keep requesting.

Reset
REQ-026 RST_n=0 SHALL immediately force state=IDLE, Q_in=16'h0000, load=0, gnt0=gnt1=0, busy=0, active_id=0, counter=0 and round-robin pointer=0 (requester 0 favoured).
REQ-027 Reset asserted mid-LOAD or mid-RUN SHALL abort without any further load pulse, and operation SHALL resume from IDLE on the first edge after RST_n rises.

Verification
REQ-028 Reset, then req0=1, pat0=16'hAAAA, dur0=4 -> load=1 and gnt0=1 for 1 cycle, Q_in=AAAA, busy=1 for 5 cycles, then IDLE.
REQ-029 req0 and req1 raised on the same edge from reset, pat1=16'hFFE0, each with dur=2, each requester re-requesting after its grant -> grant order 0,1,0,1 and active_id following that order.
REQ-030 dur1=0, pat1=16'hE000 -> one LOAD cycle, busy high for 1 cycle, return to IDLE, Q_in remaining E000.
REQ-031 dur0=10 with stop pulsed in the 3rd RUN cycle -> IDLE on that edge, no extra load, Q_in unchanged.
REQ-032 RST_n pulsed low in the 2nd RUN cycle of a dur=8 dwell -> all outputs at reset values immediately, and the next request granted normally with pointer=0.
REQ-033 req1 raised during RUN of requester 0 -> no gnt1 until requester 0's dwell ends, then gnt1 after exactly 1 IDLE cycle.
